// File: rtl/sobel_pkg.sv
// Shared widths, types and the [1,2,1] column kernel for the 3x3 Sobel filter.
package sobel_pkg;
  localparam int PIX_W  = 8;
  localparam int GRAD_W = PIX_W + 3;
  localparam int MAG_W  = PIX_W + 3;
  localparam int LAT    = 4;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [MAG_W-1:0]         mag_t;
  typedef pix_t [2:0][2:0]          window_t;

  function automatic grad_t col_sum(pix_t a, pix_t b, pix_t c);
    return grad_t'({3'b000, a}) + grad_t'({2'b00, b, 1'b0}) + grad_t'({3'b000, c});
  endfunction
endpackage

// File: rtl/sobel_line_buf.sv
// Single-port read-first line buffer: synchronous read every cycle, write on i_we.
module sobel_line_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter; edge magnitude and all timing signals leave 4 clocks
// after entry so downstream video timing stays aligned.
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int CORDW_p      = 16,
  parameter int H_RES_p      = 640,
  parameter int V_RES_p      = 480,
  parameter int PIX_W_p      = 8,
  parameter int SHIFT_p      = 2,
  parameter int THRESH_p     = 0,
  parameter int H_POLARITY_p = 0,
  parameter int V_POLARITY_p = 0
) (
  input  logic               clk_pix_i,
  input  logic               rst_pix_i,
  input  logic [PIX_W_p-1:0] pix_i,
  input  logic               de_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic               frame_i,
  input  logic [CORDW_p-1:0] sx_i,
  input  logic [CORDW_p-1:0] sy_i,
  output logic [PIX_W_p-1:0] edge_o,
  output logic               de_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               frame_o,
  output logic [CORDW_p-1:0] sx_o,
  output logic [CORDW_p-1:0] sy_o
);
  localparam int ADDR_W  = $clog2(H_RES_p);
  localparam int TW      = 4 + 2 * CORDW_p;
  localparam int PIX_MAX = (1 << PIX_W) - 1;
  localparam logic HS_IDLE = (H_POLARITY_p == 0);
  localparam logic VS_IDLE = (V_POLARITY_p == 0);
  localparam logic [TW-1:0] T_RST = {1'b0, HS_IDLE, VS_IDLE, 1'b0, {(2 * CORDW_p){1'b0}}};

  logic              w_we0, w_ok0;
  logic [ADDR_W-1:0] w_addr0;
  pix_t              w_lb0_rd, w_lb1_rd;
  logic              r_frame_ok;
  logic              r1_de, r1_we, r1_ok;
  logic [ADDR_W-1:0] r1_addr;
  pix_t              r1_pix;
  logic              r2_de, r2_ok;
  pix_t              r2_pix, r2_row1;
  pix_t [1:0][2:0]   r_win;
  pix_t [2:0]        w_col;
  window_t           w_win;
  grad_t             w_gx, w_gy, r3_gx, r3_gy;
  logic              r3_ok;
  mag_t              w_ax, w_ay, w_mag, w_m;
  pix_t              w_edge, r_edge;
  logic [TW-1:0]     r_dly [LAT];

  // Centre (x-1,y-1) is valid only once two full columns and rows of this frame exist.
  assign w_we0   = de_i && !sx_i[CORDW_p-1];
  assign w_addr0 = w_we0 ? sx_i[ADDR_W-1:0] : '0;
  assign w_ok0   = de_i && r_frame_ok
                 && !sx_i[CORDW_p-1] && (sx_i[CORDW_p-1:1] != '0)
                 && !sy_i[CORDW_p-1] && (sy_i[CORDW_p-1:1] != '0)
                 && (sy_i < CORDW_p'(V_RES_p));

  sobel_line_buf #(.DATA_W(PIX_W), .DEPTH(H_RES_p), .ADDR_W(ADDR_W)) u_lb0 (
    .i_clk(clk_pix_i), .i_we(w_we0), .i_addr(w_addr0), .i_wdata(pix_i), .o_rdata(w_lb0_rd)
  );

  // lb1 is fed one cycle behind lb0 with lb0's pre-write data, so its read lands in stage 2.
  sobel_line_buf #(.DATA_W(PIX_W), .DEPTH(H_RES_p), .ADDR_W(ADDR_W)) u_lb1 (
    .i_clk(clk_pix_i), .i_we(r1_we), .i_addr(r1_addr), .i_wdata(w_lb0_rd), .o_rdata(w_lb1_rd)
  );

  assign w_col = {r2_pix, r2_row1, w_lb1_rd};
  assign w_win = {w_col, r_win};
  assign w_gx  = col_sum(w_win[2][0], w_win[2][1], w_win[2][2])
               - col_sum(w_win[0][0], w_win[0][1], w_win[0][2]);
  assign w_gy  = col_sum(w_win[0][2], w_win[1][2], w_win[2][2])
               - col_sum(w_win[0][0], w_win[1][0], w_win[2][0]);

  always_comb begin
    w_ax  = r3_gx[GRAD_W-1] ? mag_t'(-r3_gx) : mag_t'(r3_gx);
    w_ay  = r3_gy[GRAD_W-1] ? mag_t'(-r3_gy) : mag_t'(r3_gy);
    w_mag = w_ax + w_ay;
    w_m   = w_mag >> SHIFT_p;
    if (THRESH_p > 0) w_edge = (w_m >= MAG_W'(THRESH_p)) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
    else              w_edge = (w_m > MAG_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : w_m[PIX_W-1:0];
  end

  always_ff @(posedge clk_pix_i or posedge rst_pix_i) begin
    if (rst_pix_i) begin
      r_frame_ok <= 1'b0;
      r1_de      <= 1'b0;
      r1_we      <= 1'b0;
      r1_ok      <= 1'b0;
      r1_addr    <= '0;
      r1_pix     <= '0;
      r2_de      <= 1'b0;
      r2_ok      <= 1'b0;
      r2_pix     <= '0;
      r2_row1    <= '0;
      r_win      <= '0;
      r3_gx      <= '0;
      r3_gy      <= '0;
      r3_ok      <= 1'b0;
      r_edge     <= '0;
    end else begin
      if (frame_i) r_frame_ok <= 1'b1;
      r1_de   <= de_i;
      r1_we   <= w_we0;
      r1_ok   <= w_ok0;
      r1_addr <= w_addr0;
      r1_pix  <= pix_i;
      r2_de   <= r1_de;
      r2_ok   <= r1_ok;
      r2_pix  <= r1_pix;
      r2_row1 <= w_lb0_rd;
      if (r2_de) begin
        r_win[0] <= r_win[1];
        r_win[1] <= w_col;
      end
      r3_gx  <= w_gx;
      r3_gy  <= w_gy;
      r3_ok  <= r2_ok;
      r_edge <= r3_ok ? w_edge : '0;
    end
  end

  always_ff @(posedge clk_pix_i or posedge rst_pix_i) begin
    if (rst_pix_i) begin
      for (int i = 0; i < LAT; i++) r_dly[i] <= T_RST;
    end else begin
      r_dly[0] <= {de_i, hsync_i, vsync_i, frame_i, sx_i, sy_i};
      for (int i = 1; i < LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign {de_o, hsync_o, vsync_o, frame_o, sx_o, sy_o} = r_dly[LAT-1];
  assign edge_o = r_edge;
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter on a reduced 16x12 raster (24x16 total).
module tb_sobel_stream_filter;
  localparam int HR = 16, VR = 12, HB = 8, VB = 4;
  localparam int LINE = HR + HB;
  localparam int FRAME = LINE * (VR + VB);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] pix_i = '0;
  logic de_i = 1'b0, frame_i = 1'b0;
  logic hs_a = 1'b1, vs_a = 1'b1, hs_b = 1'b0, vs_b = 1'b0;
  logic [15:0] sx_i = '0, sy_i = '0;
  logic [7:0] a_edge, b_edge;
  logic a_de, a_hs, a_vs, a_fr, b_de, b_hs, b_vs, b_fr;
  logic [15:0] a_sx, a_sy, b_sx, b_sy;

  int n_checks = 0, n_errors = 0;
  int tsx = -HB, tsy = -VB, mode = 0, amp = 0, hist_n = 0;
  logic hde[4], hha[4], hva[4], hfr[4];
  int hsx[4], hsy[4];

  always #5 clk = ~clk;

  sobel_stream_filter #(.CORDW_p(16), .H_RES_p(HR), .V_RES_p(VR), .PIX_W_p(8), .SHIFT_p(2),
    .THRESH_p(0), .H_POLARITY_p(0), .V_POLARITY_p(0)) dut_a (
    .clk_pix_i(clk), .rst_pix_i(rst), .pix_i(pix_i), .de_i(de_i), .hsync_i(hs_a), .vsync_i(vs_a),
    .frame_i(frame_i), .sx_i(sx_i), .sy_i(sy_i), .edge_o(a_edge), .de_o(a_de), .hsync_o(a_hs),
    .vsync_o(a_vs), .frame_o(a_fr), .sx_o(a_sx), .sy_o(a_sy));

  sobel_stream_filter #(.CORDW_p(16), .H_RES_p(HR), .V_RES_p(VR), .PIX_W_p(8), .SHIFT_p(0),
    .THRESH_p(100), .H_POLARITY_p(1), .V_POLARITY_p(1)) dut_b (
    .clk_pix_i(clk), .rst_pix_i(rst), .pix_i(pix_i), .de_i(de_i), .hsync_i(hs_b), .vsync_i(vs_b),
    .frame_i(frame_i), .sx_i(sx_i), .sy_i(sy_i), .edge_o(b_edge), .de_o(b_de), .hsync_o(b_hs),
    .vsync_o(b_vs), .frame_o(b_fr), .sx_o(b_sx), .sy_o(b_sy));

  function automatic logic [7:0] img(int x, int y);
    case (mode)
      1:       return (x >= 8) ? 8'(amp) : 8'd0;
      2:       return (y >= 6) ? 8'(amp) : 8'd0;
      default: return 8'd128;
    endcase
  endfunction

  // Drives one raster position, clocks it in, records it, and returns at the next negedge.
  task automatic step();
    logic d, f, h_act, v_act;
    d = (tsx >= 0) && (tsy >= 0);
    f = (tsx == -HB) && (tsy == -VB);
    h_act = (tsx >= -6) && (tsx < -3);
    v_act = (tsy == -3);
    de_i = d; frame_i = f;
    hs_a = ~h_act; hs_b = h_act; vs_a = ~v_act; vs_b = v_act;
    sx_i = 16'(tsx); sy_i = 16'(tsy);
    pix_i = d ? img(tsx, tsy) : 8'h5a;
    @(posedge clk);
    for (int i = 3; i > 0; i--) begin
      hde[i] = hde[i-1]; hha[i] = hha[i-1]; hva[i] = hva[i-1];
      hfr[i] = hfr[i-1]; hsx[i] = hsx[i-1]; hsy[i] = hsy[i-1];
    end
    hde[0] = d; hha[0] = h_act; hva[0] = v_act; hfr[0] = f; hsx[0] = tsx; hsy[0] = tsy;
    if (rst) hist_n = 0;
    else if (hist_n < 4) hist_n++;
    tsx++;
    if (tsx == HR) begin
      tsx = -HB;
      tsy++;
      if (tsy == VR) tsy = -VB;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (a_edge !== 8'd0) begin n_errors++; $display("FAIL reset_edge got %0d exp 0", a_edge); end
    n_checks++; if (a_de !== 1'b0) begin n_errors++; $display("FAIL reset_de got %b exp 0", a_de); end
    n_checks++; if (a_fr !== 1'b0) begin n_errors++; $display("FAIL reset_frame got %b exp 0", a_fr); end
    n_checks++; if (a_hs !== 1'b1) begin n_errors++; $display("FAIL reset_hs_neg got %b exp 1", a_hs); end
    n_checks++; if (a_vs !== 1'b1) begin n_errors++; $display("FAIL reset_vs_neg got %b exp 1", a_vs); end
    n_checks++; if (b_hs !== 1'b0) begin n_errors++; $display("FAIL reset_hs_pos got %b exp 0", b_hs); end
    n_checks++; if (b_vs !== 1'b0) begin n_errors++; $display("FAIL reset_vs_pos got %b exp 0", b_vs); end
    n_checks++; if (a_sx !== 16'd0) begin n_errors++; $display("FAIL reset_sx got %0d exp 0", a_sx); end
    n_checks++; if (a_sy !== 16'd0) begin n_errors++; $display("FAIL reset_sy got %0d exp 0", a_sy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hde[i] = 1'b0; hha[i] = 1'b0; hva[i] = 1'b0; hfr[i] = 1'b0; hsx[i] = 0; hsy[i] = 0;
    end
    hist_n = 0;
  endtask

  task automatic test_uniform();
    mode = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step();
      if (hist_n >= 4) begin
        n_checks++; if (a_de !== hde[3]) begin n_errors++; $display("FAIL uniform_de got %b exp %b", a_de, hde[3]); end
        if (c >= FRAME && hde[3]) begin
          n_checks++; if (a_edge !== 8'd0) begin n_errors++; $display("FAIL uniform_edge got %0d exp 0 at %0d,%0d", a_edge, hsx[3], hsy[3]); end
        end
      end
    end
  endtask

  task automatic test_vstep();
    logic [7:0] ea;
    mode = 1; amp = 255;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step();
      ea = (hde[3] && hsx[3] >= 2 && hsy[3] >= 2 && (hsx[3] == 8 || hsx[3] == 9)) ? 8'd255 : 8'd0;
      if (hist_n >= 4 && c >= FRAME) begin
        n_checks++; if (a_edge !== ea) begin n_errors++; $display("FAIL vstep_edge_a got %0d exp %0d at %0d,%0d", a_edge, ea, hsx[3], hsy[3]); end
        n_checks++; if (b_edge !== ea) begin n_errors++; $display("FAIL vstep_edge_b got %0d exp %0d at %0d,%0d", b_edge, ea, hsx[3], hsy[3]); end
      end
    end
  endtask

  task automatic test_hstep();
    logic [7:0] ea;
    mode = 2; amp = 255;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step();
      ea = (hde[3] && hsx[3] >= 2 && hsy[3] >= 2 && (hsy[3] == 6 || hsy[3] == 7)) ? 8'd255 : 8'd0;
      if (hist_n >= 4 && c >= FRAME) begin
        n_checks++; if (a_edge !== ea) begin n_errors++; $display("FAIL hstep_edge got %0d exp %0d at %0d,%0d", a_edge, ea, hsx[3], hsy[3]); end
      end
    end
  endtask

  task automatic test_thresh();
    int t_amp[2] = '{20, 40};
    logic [7:0] t_b[2] = '{8'd0, 8'd255};
    logic ec;
    logic [7:0] ea, eb;
    mode = 1;
    for (int t = 0; t < 2; t++) begin
      amp = t_amp[t];
      for (int c = 0; c < 2 * FRAME; c++) begin
        step();
        ec = hde[3] && hsx[3] >= 2 && hsy[3] >= 2 && (hsx[3] == 8 || hsx[3] == 9);
        ea = ec ? 8'(t_amp[t]) : 8'd0;
        eb = ec ? t_b[t] : 8'd0;
        if (hist_n >= 4 && c >= FRAME) begin
          n_checks++; if (a_edge !== ea) begin n_errors++; $display("FAIL thresh_mag_a amp %0d got %0d exp %0d", amp, a_edge, ea); end
          n_checks++; if (b_edge !== eb) begin n_errors++; $display("FAIL thresh_bin_b amp %0d got %0d exp %0d", amp, b_edge, eb); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ea;
    mode = 1; amp = 255;
    for (int k = 0; k < 2 * FRAME && !(tsy == 5 && tsx == 12); k++) step();
    ea = (hde[3] && hsx[3] >= 2 && hsy[3] >= 2 && (hsx[3] == 8 || hsx[3] == 9)) ? 8'd255 : 8'd0;
    n_checks++; if (a_edge !== ea) begin n_errors++; $display("FAIL midrst_pre_edge got %0d exp %0d", a_edge, ea); end
    rst = 1'b1;
    #1;
    n_checks++; if (a_edge !== 8'd0) begin n_errors++; $display("FAIL midrst_async_edge got %0d exp 0", a_edge); end
    n_checks++; if (a_de !== 1'b0) begin n_errors++; $display("FAIL midrst_async_de got %b exp 0", a_de); end
    n_checks++; if (a_sx !== 16'd0) begin n_errors++; $display("FAIL midrst_async_sx got %0d exp 0", a_sx); end
    n_checks++; if (a_sy !== 16'd0) begin n_errors++; $display("FAIL midrst_async_sy got %0d exp 0", a_sy); end
    repeat (3) step();
    rst = 1'b0;
    for (int k = 0; k < 2 * FRAME && !(tsx == -HB && tsy == -VB); k++) begin
      step();
      n_checks++; if (a_edge !== 8'd0) begin n_errors++; $display("FAIL midrst_stale_edge got %0d exp 0 at %0d,%0d", a_edge, hsx[3], hsy[3]); end
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      step();
      ea = (hde[3] && hsx[3] >= 2 && hsy[3] >= 2 && (hsx[3] == 8 || hsx[3] == 9)) ? 8'd255 : 8'd0;
      if (hist_n >= 4 && c >= FRAME) begin
        n_checks++; if (a_edge !== ea) begin n_errors++; $display("FAIL midrst_frame2_edge got %0d exp %0d at %0d,%0d", a_edge, ea, hsx[3], hsy[3]); end
      end
    end
  endtask

  task automatic test_timing();
    for (int c = 0; c < 2 * FRAME; c++) begin
      step();
      if (hist_n >= 4) begin
        n_checks++; if (a_de !== hde[3] || b_de !== hde[3]) begin n_errors++; $display("FAIL timing_de got %b/%b exp %b", a_de, b_de, hde[3]); end
        n_checks++; if (a_hs !== ~hha[3]) begin n_errors++; $display("FAIL timing_hs_neg got %b exp %b", a_hs, ~hha[3]); end
        n_checks++; if (b_hs !== hha[3]) begin n_errors++; $display("FAIL timing_hs_pos got %b exp %b", b_hs, hha[3]); end
        n_checks++; if (a_vs !== ~hva[3]) begin n_errors++; $display("FAIL timing_vs_neg got %b exp %b", a_vs, ~hva[3]); end
        n_checks++; if (b_vs !== hva[3]) begin n_errors++; $display("FAIL timing_vs_pos got %b exp %b", b_vs, hva[3]); end
        n_checks++; if (a_fr !== hfr[3] || b_fr !== hfr[3]) begin n_errors++; $display("FAIL timing_frame got %b/%b exp %b", a_fr, b_fr, hfr[3]); end
        n_checks++; if (a_sx !== 16'(hsx[3]) || b_sx !== 16'(hsx[3])) begin n_errors++; $display("FAIL timing_sx got %0d/%0d exp %0d", $signed(a_sx), $signed(b_sx), hsx[3]); end
        n_checks++; if (a_sy !== 16'(hsy[3]) || b_sy !== 16'(hsy[3])) begin n_errors++; $display("FAIL timing_sy got %0d/%0d exp %0d", $signed(a_sy), $signed(b_sy), hsy[3]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_vstep();
    test_hstep();
    test_thresh();
    test_reset_mid();
    test_timing();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
